// File: rtl/page_walker_if.sv
// Request/response and page-table RAM signals shared between the core side,
// the translation controller and the page-table memory.
interface page_walker_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_write;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        resp_fault_level;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_vaddr, req_write, mem_rdata,
    output req_ready, resp_valid, resp_paddr, resp_fault, resp_fault_level,
           mem_re, mem_addr
  );

  modport master (
    output req_valid, req_vaddr, req_write, mem_rdata,
    input  req_ready, resp_valid, resp_paddr, resp_fault, resp_fault_level,
           mem_re, mem_addr
  );
endinterface

// File: rtl/page_walker.sv
// Sv32 translation controller: bare pass-through, a small fully-associative
// TLB, and a two-level page-table walker sequencing PTE reads on the RAM port.
module page_walker #(
  parameter int TLB_ENTRIES = 4
) (
  input  logic         clock,
  input  logic         RST,
  input  logic [31:0]  sptbr,
  input  logic         flush,
  page_walker_if.slave bus
);
  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L1_REQ = 3'd1,
    L1_CHK = 3'd2,
    L0_REQ = 3'd3,
    L0_CHK = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      vaddr_q, vaddr_d;
  logic             write_q, write_d;
  logic             drop_fill_q, drop_fill_d;
  logic             mem_re_q, mem_re_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_paddr_q, resp_paddr_d;
  logic             resp_fault_q, resp_fault_d;
  logic             resp_level_q, resp_level_d;
  logic [TLB_ENTRIES-1:0] tlb_valid_q, tlb_valid_d;
  logic [TLB_ENTRIES-1:0] tlb_wr_ok_q, tlb_wr_ok_d;
  logic [19:0]      tlb_tag_q [TLB_ENTRIES];
  logic [19:0]      tlb_tag_d [TLB_ENTRIES];
  logic [19:0]      tlb_ppn_q [TLB_ENTRIES];
  logic [19:0]      tlb_ppn_d [TLB_ENTRIES];
  logic [IDX_W-1:0] victim_q, victim_d;

  logic             hit_s;
  logic [19:0]      hit_ppn_s;
  logic [31:0]      pte_s;
  logic             is_l1_s, leaf_s, pte_bad_s, perm_bad_s, misaligned_s;
  logic [31:0]      leaf_paddr_s;
  logic             unused_ok_s;

  // TLB lookup; a write needs wr_ok, and the lowest matching entry wins.
  always_comb begin
    logic match;
    hit_s     = 1'b0;
    hit_ppn_s = 20'h0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      match     = tlb_valid_q[i] && (tlb_tag_q[i] == bus.req_vaddr[31:12]) &&
                  !(bus.req_write && !tlb_wr_ok_q[i]);
      hit_ppn_s = (match && !hit_s) ? tlb_ppn_q[i] : hit_ppn_s;
      hit_s     = hit_s | match;
    end
  end

  assign pte_s        = bus.mem_rdata;
  assign is_l1_s      = (state_q == L1_CHK);
  assign leaf_s       = pte_s[1] | pte_s[3];
  assign pte_bad_s    = !pte_s[0] || (!pte_s[1] && pte_s[2]);
  assign perm_bad_s   = !pte_s[6] || (write_q && (!pte_s[2] || !pte_s[7]));
  assign misaligned_s = is_l1_s && (pte_s[19:10] != 10'h0);
  assign leaf_paddr_s = is_l1_s ? {pte_s[29:20], vaddr_q[21:0]}
                                : {pte_s[29:10], vaddr_q[11:0]};
  assign unused_ok_s  = ^{sptbr[30:20], pte_s[31:30], pte_s[9:8], pte_s[5:4]};

  // Next-state, walk sequencing, response capture and TLB fill.
  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    write_d      = write_q;
    drop_fill_d  = drop_fill_q;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = 1'b0;
    resp_paddr_d = resp_paddr_q;
    resp_fault_d = resp_fault_q;
    resp_level_d = resp_level_q;
    tlb_valid_d  = tlb_valid_q;
    tlb_wr_ok_d  = tlb_wr_ok_q;
    tlb_tag_d    = tlb_tag_q;
    tlb_ppn_d    = tlb_ppn_q;
    victim_d     = victim_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          vaddr_d     = bus.req_vaddr;
          write_d     = bus.req_write;
          drop_fill_d = 1'b0;
          if (!sptbr[31]) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_paddr_d = bus.req_vaddr;
            resp_fault_d = 1'b0;
            resp_level_d = 1'b0;
          end else if (hit_s && !flush) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_paddr_d = {hit_ppn_s, bus.req_vaddr[11:0]};
            resp_fault_d = 1'b0;
            resp_level_d = 1'b0;
          end else begin
            state_d    = L1_REQ;
            mem_re_d   = 1'b1;
            mem_addr_d = {sptbr[19:0], bus.req_vaddr[31:22], 2'b00};
          end
        end else begin
          state_d = IDLE;
        end
      end
      L1_REQ: state_d = L1_CHK;
      L0_REQ: state_d = L0_CHK;
      L1_CHK, L0_CHK: begin
        if (pte_bad_s || (leaf_s && (perm_bad_s || misaligned_s)) ||
            (!leaf_s && !is_l1_s)) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_paddr_d = 32'h0;
          resp_fault_d = 1'b1;
          resp_level_d = is_l1_s;
        end else if (leaf_s) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_paddr_d = leaf_paddr_s;
          resp_fault_d = 1'b0;
          resp_level_d = 1'b0;
          if (!drop_fill_q && !flush) begin
            tlb_valid_d[victim_q] = 1'b1;
            tlb_wr_ok_d[victim_q] = pte_s[2] & pte_s[7];
            tlb_tag_d[victim_q]   = vaddr_q[31:12];
            tlb_ppn_d[victim_q]   = leaf_paddr_s[31:12];
            victim_d = (victim_q == LAST_IDX) ? '0 : victim_q + IDX_W'(1);
          end else begin
            victim_d = victim_q;
          end
        end else begin
          state_d    = L0_REQ;
          mem_re_d   = 1'b1;
          mem_addr_d = {pte_s[29:10], vaddr_q[21:12], 2'b00};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush during a walk suppresses that walk's fill.
    drop_fill_d = (flush && (state_q != IDLE)) ? 1'b1 : drop_fill_d;
    tlb_valid_d = flush ? '0 : tlb_valid_d;
    victim_d    = flush ? '0 : victim_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (RST) begin
      state_q      <= IDLE;
      vaddr_q      <= 32'h0;
      write_q      <= 1'b0;
      drop_fill_q  <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= 32'h0;
      resp_fault_q <= 1'b0;
      resp_level_q <= 1'b0;
      tlb_valid_q  <= '0;
      tlb_wr_ok_q  <= '0;
      victim_q     <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_tag_q[i] <= 20'h0;
        tlb_ppn_q[i] <= 20'h0;
      end
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      write_q      <= write_d;
      drop_fill_q  <= drop_fill_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_fault_q <= resp_fault_d;
      resp_level_q <= resp_level_d;
      tlb_valid_q  <= tlb_valid_d;
      tlb_wr_ok_q  <= tlb_wr_ok_d;
      victim_q     <= victim_d;
      tlb_tag_q    <= tlb_tag_d;
      tlb_ppn_q    <= tlb_ppn_d;
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_paddr       = resp_paddr_q;
  assign bus.resp_fault       = resp_fault_q;
  assign bus.resp_fault_level = resp_level_q;
  assign bus.mem_re           = mem_re_q;
  assign bus.mem_addr         = mem_addr_q;
endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: page-table memory model, expected-response
// scoreboard and an expected-PTE-address queue checked on every mem_re.
module tb_page_walker;
  logic        clock = 1'b0;
  logic        RST;
  logic [31:0] sptbr;
  logic        flush;

  page_walker_if bus_if();

  page_walker #(.TLB_ENTRIES(4)) dut (
    .clock (clock),
    .RST   (RST),
    .sptbr (sptbr),
    .flush (flush),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] paddr;
    logic        fault;
    logic        level;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mem_exp_q[$];
  logic [31:0] pmem [logic [31:0]];
  int          checks   = 0;
  int          failures = 0;
  logic        mem_re_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Page-table RAM: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (bus_if.mem_re)
      bus_if.mem_rdata <= pmem.exists(bus_if.mem_addr) ? pmem[bus_if.mem_addr] : 32'h0;
  end

  // Every PTE read must be expected, in order, and be a one-cycle pulse.
  always @(negedge clock) begin
    if (!RST && bus_if.mem_re) begin
      check("mem_re_pulse", {31'd0, mem_re_prev}, 32'd0);
      if (mem_exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_mem_re observed=0x%08h expected=none", bus_if.mem_addr);
      end else begin
        check("mem_addr", bus_if.mem_addr, mem_exp_q.pop_front());
      end
    end
    mem_re_prev = bus_if.mem_re;
  end

  task automatic do_req(input logic [31:0] va, input logic wr, input logic fl,
                        input logic [31:0] pa, input logic flt, input logic lvl,
                        input int lat);
    int    cyc;
    resp_t e;
    resp_t got;
    @(negedge clock);
    check("req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_vaddr = va;
    bus_if.req_write = wr;
    flush            = fl;
    e.paddr = pa;
    e.fault = flt;
    e.level = lvl;
    exp_q.push_back(e);
    cyc = 0;
    do begin
      @(negedge clock);
      bus_if.req_valid = 1'b0;
      flush            = 1'b0;
      cyc++;
    end while (!bus_if.resp_valid && cyc < 12);
    check("resp_seen", {31'd0, bus_if.resp_valid}, 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    got = exp_q.pop_front();
    if (bus_if.resp_valid) begin
      check("resp_paddr", bus_if.resp_paddr, got.paddr);
      check("resp_fault", {31'd0, bus_if.resp_fault}, {31'd0, got.fault});
      check("resp_level", {31'd0, bus_if.resp_fault_level}, {31'd0, got.level});
    end
    check("mem_reads_left", 32'(mem_exp_q.size()), 32'd0);
    mem_exp_q.delete();
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  initial begin
    RST              = 1'b1;
    sptbr            = 32'h0;
    flush            = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_vaddr = 32'h0;
    bus_if.req_write = 1'b0;
    pmem[32'h0000_1004] = 32'h0000_0801;
    pmem[32'h0000_200C] = 32'h0001_54C7;
    pmem[32'h0000_100C] = 32'h0010_004F;
    repeat (3) @(negedge clock);
    check("rst_req_ready",  {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_resp_paddr", bus_if.resp_paddr, 32'h0);
    check("rst_resp_fault", {31'd0, bus_if.resp_fault}, 32'd0);
    check("rst_mem_re",     {31'd0, bus_if.mem_re}, 32'd0);
    check("rst_mem_addr",   bus_if.mem_addr, 32'h0);
    RST   = 1'b0;
    sptbr = 32'h8000_0001;

    // Full two-level walk, then the same page as a write hits the TLB.
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_200C);
    do_req(32'h0040_3ABC, 1'b0, 1'b0, 32'h0005_5ABC, 1'b0, 1'b0, 5);
    @(negedge clock);
    check("hold_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("hold_paddr", bus_if.resp_paddr, 32'h0005_5ABC);
    do_req(32'h0040_3ABC, 1'b1, 1'b0, 32'h0005_5ABC, 1'b0, 1'b0, 1);

    // Superpage, then a misaligned superpage on a different 4 KiB page.
    mem_exp_q.push_back(32'h0000_100C);
    do_req(32'h00C0_1234, 1'b0, 1'b0, 32'h0040_1234, 1'b0, 1'b0, 3);
    pmem[32'h0000_100C] = 32'h0010_044F;
    mem_exp_q.push_back(32'h0000_100C);
    do_req(32'h00C0_2234, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);

    // Flush with the request forces a walk; clean page store faults at level 0.
    pmem[32'h0000_200C] = 32'h0001_5447;
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_200C);
    do_req(32'h0040_3ABC, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 5);
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_200C);
    do_req(32'h0040_3ABC, 1'b0, 1'b0, 32'h0005_5ABC, 1'b0, 1'b0, 5);
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_200C);
    do_req(32'h0040_3ABC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5);

    // Bare mode passes the address straight through.
    sptbr = 32'h0;
    do_req(32'h0000_1234, 1'b0, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1);
    do_req(32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    sptbr = 32'h8000_0001;

    // Round-robin eviction over five fills.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      pmem[32'h0000_2000 + 32'(4 * i)] = ((32'h100 + 32'(i)) << 10) | 32'h0000_00C7;
    end
    for (int i = 0; i < 5; i++) begin
      mem_exp_q.push_back(32'h0000_1004);
      mem_exp_q.push_back(32'h0000_2000 + 32'(4 * i));
      do_req(32'h0040_0010 | (32'(i) << 12), 1'b0, 1'b0,
             ((32'h100 + 32'(i)) << 12) | 32'h10, 1'b0, 1'b0, 5);
    end
    do_req(32'h0040_4010, 1'b0, 1'b0, 32'h0010_4010, 1'b0, 1'b0, 1);
    do_req(32'h0040_1010, 1'b1, 1'b0, 32'h0010_1010, 1'b0, 1'b0, 1);
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_2000);
    do_req(32'h0040_0010, 1'b0, 1'b0, 32'h0010_0010, 1'b0, 1'b0, 5);

    // Standalone flush empties the TLB.
    do_flush();
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_2010);
    do_req(32'h0040_4010, 1'b0, 1'b0, 32'h0010_4010, 1'b0, 1'b0, 5);

    // Reset while the leaf PTE is being checked aborts the walk.
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_2008);
    @(negedge clock);
    bus_if.req_valid = 1'b1;
    bus_if.req_vaddr = 32'h0040_2010;
    bus_if.req_write = 1'b0;
    repeat (4) begin
      @(negedge clock);
      bus_if.req_valid = 1'b0;
    end
    check("midwalk_mem_addr", bus_if.mem_addr, 32'h0000_2008);
    RST = 1'b1;
    @(negedge clock);
    RST = 1'b0;
    check("abort_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("abort_req_ready",  {31'd0, bus_if.req_ready}, 32'd1);
    check("abort_mem_re",     {31'd0, bus_if.mem_re}, 32'd0);
    check("abort_reads_left", 32'(mem_exp_q.size()), 32'd0);
    mem_exp_q.delete();
    mem_exp_q.push_back(32'h0000_1004);
    mem_exp_q.push_back(32'h0000_2010);
    do_req(32'h0040_4010, 1'b0, 1'b0, 32'h0010_4010, 1'b0, 1'b0, 5);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
